register_restore: RTL and testbench

Rollback engine for branch-misprediction recovery; consumer side of the register snapshot path.
- Tracks which architectural registers are written after a snapshot is taken.
- On a restore request, writes only those dirty registers back into the register file, one register per cycle, from the held snapshot image.
- Sits between hazard control and the register file write port; holds the pipeline stalled while the restore runs.

---
 rtl/register_restore_pkg.sv | 14 +
 rtl/priority_enc_lsb.sv | 21 ++
 rtl/register_restore.sv | 77 +++++++
 tb/tb_register_restore.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/register_restore_pkg.sv
// rtl/register_restore_pkg.sv - shared constants and state type for the register rollback engine
package register_restore_pkg;

  localparam int N_REGS     = 32;
  localparam int ADDR_W     = $clog2(N_REGS);
  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESTORE = 2'd1,
    DONE    = 2'd2
  } restore_state_t;

endpackage

// File: rtl/priority_enc_lsb.sv
// rtl/priority_enc_lsb.sv - index of the lowest set bit in a mask, plus an any-set flag
module priority_enc_lsb #(
  parameter int N = 32,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] mask,
  output logic [W-1:0] idx,
  output logic         any
);

  // Scan high to low so the lowest set bit is the last assignment.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) idx = W'(i);
    end
  end

  assign any = |mask;

endmodule

// File: rtl/register_restore.sv
// rtl/register_restore.sv - dirty-register tracking and one-per-cycle rollback from a held snapshot
module register_restore
  import register_restore_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                take_snapshot,
  input  logic [N_REGS-1:0][DATA_WIDTH-1:0]   regs_snapshot,
  input  logic                                rf_wr_en,
  input  logic [ADDR_W-1:0]                   rf_wr_addr,
  input  logic                                restore_req,
  output logic                                restore_wr_en,
  output logic [ADDR_W-1:0]                   restore_wr_addr,
  output logic [DATA_WIDTH-1:0]               restore_wr_data,
  output logic                                restore_busy,
  output logic                                restore_done
);

  restore_state_t    state_q, state_d;
  logic [N_REGS-1:0] dirty_q, dirty_d, track;
  logic              snap_q, snap_d;
  logic [ADDR_W-1:0] lsb_idx;
  logic              any_set;

  priority_enc_lsb #(.N(N_REGS), .W(ADDR_W)) u_enc (
    .mask (dirty_q),
    .idx  (lsb_idx),
    .any  (any_set)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dirty_q <= '0;
      snap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dirty_q <= dirty_d;
      snap_q  <= snap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dirty_d = dirty_q;
    snap_d  = snap_q;
    track   = dirty_q;
    case (state_q)
      IDLE: begin
        // Clear then set: a write in the snapshot cycle belongs to the new path.
        if (take_snapshot) begin
          track  = '0;
          snap_d = 1'b1;
        end
        if (rf_wr_en && rf_wr_addr != '0) track[rf_wr_addr] = 1'b1;
        dirty_d = track;
        if (restore_req) state_d = (snap_d && track != '0) ? RESTORE : DONE;
      end
      RESTORE: begin
        dirty_d = dirty_q & ~({{(N_REGS-1){1'b0}}, 1'b1} << lsb_idx);
        if (dirty_d == '0) state_d = DONE;
      end
      DONE: begin
        dirty_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign restore_busy    = (state_q != IDLE);
  assign restore_done    = (state_q == DONE);
  assign restore_wr_en   = (state_q == RESTORE) && any_set;
  assign restore_wr_addr = restore_wr_en ? lsb_idx : '0;
  assign restore_wr_data = restore_wr_en ? regs_snapshot[restore_wr_addr] : '0;

endmodule

// File: tb/tb_register_restore.sv
// tb/tb_register_restore.sv - directed and randomized checks of register_restore against a queue-based model
module tb_register_restore;
  import register_restore_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                              rst;
  logic                              take_snapshot;
  logic [N_REGS-1:0][DATA_WIDTH-1:0] regs_snapshot;
  logic                              rf_wr_en;
  logic [ADDR_W-1:0]                 rf_wr_addr;
  logic                              restore_req;
  logic                              restore_wr_en;
  logic [ADDR_W-1:0]                 restore_wr_addr;
  logic [DATA_WIDTH-1:0]             restore_wr_data;
  logic                              restore_busy;
  logic                              restore_done;

  register_restore dut (
    .clk             (clk),
    .rst             (rst),
    .take_snapshot   (take_snapshot),
    .regs_snapshot   (regs_snapshot),
    .rf_wr_en        (rf_wr_en),
    .rf_wr_addr      (rf_wr_addr),
    .restore_req     (restore_req),
    .restore_wr_en   (restore_wr_en),
    .restore_wr_addr (restore_wr_addr),
    .restore_wr_data (restore_wr_data),
    .restore_busy    (restore_busy),
    .restore_done    (restore_done)
  );

  typedef struct {
    bit       en;
    bit [4:0] addr;
    bit       busy;
    bit       done;
  } exp_t;

  exp_t exp_q[$];
  bit   m_dirty [N_REGS];
  bit   m_snap;
  int   errors = 0;
  int   checks = 0;
  int   wr_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Reference: a restore is a list of future cycles, one per dirty register in ascending order, then a done cycle.
  task automatic model_edge(input bit r, input bit ts, input bit we, input int wa, input bit rr);
    if (r) begin
      exp_q.delete();
      foreach (m_dirty[i]) m_dirty[i] = 1'b0;
      m_snap = 1'b0;
      return;
    end
    if (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      return;
    end
    if (ts) begin
      foreach (m_dirty[i]) m_dirty[i] = 1'b0;
      m_snap = 1'b1;
    end
    if (we && wa != 0) m_dirty[wa] = 1'b1;
    if (rr) begin
      for (int i = 1; i < N_REGS; i++)
        if (m_snap && m_dirty[i]) exp_q.push_back('{en: 1'b1, addr: 5'(i), busy: 1'b1, done: 1'b0});
      exp_q.push_back('{en: 1'b0, addr: 5'd0, busy: 1'b1, done: 1'b1});
      foreach (m_dirty[i]) m_dirty[i] = 1'b0;
    end
  endtask

  task automatic check_outputs();
    exp_t e;
    logic [31:0] d;
    e = '{en: 1'b0, addr: 5'd0, busy: 1'b0, done: 1'b0};
    if (exp_q.size() > 0) e = exp_q[0];
    d = e.en ? regs_snapshot[e.addr] : 32'd0;
    if (restore_wr_en === 1'b1) wr_seen++;
    chk("wr_en",   32'(restore_wr_en),   32'(e.en));
    chk("wr_addr", 32'(restore_wr_addr), 32'(e.addr));
    chk("wr_data", restore_wr_data,      d);
    chk("busy",    32'(restore_busy),    32'(e.busy));
    chk("done",    32'(restore_done),    32'(e.done));
  endtask

  task automatic step(input bit r, input bit ts, input bit we, input int wa, input bit rr);
    rst           = r;
    take_snapshot = ts;
    rf_wr_en      = we;
    rf_wr_addr    = ADDR_W'(wa);
    restore_req   = rr;
    // The image only changes when the design will actually capture it.
    if (ts && !r && exp_q.size() == 0)
      for (int i = 1; i < N_REGS; i++) regs_snapshot[i] = $urandom;
    @(posedge clk);
    model_edge(r, ts, we, wa, rr);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; take_snapshot = 1'b0; rf_wr_en = 1'b0; rf_wr_addr = '0; restore_req = 1'b0;
    regs_snapshot = '0;
    m_snap = 1'b0;
    foreach (m_dirty[i]) m_dirty[i] = 1'b0;

    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // r3, r7, r3 then restore
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 3, 0);
    step(0, 0, 1, 7, 0);
    step(0, 0, 1, 3, 0);
    wr_seen = 0;
    step(0, 0, 0, 0, 1);
    idle(4);
    chk("writes_r3_r7", 32'(wr_seen), 32'd2);

    // nothing dirty since the last rollback
    step(0, 0, 0, 0, 1);
    idle(2);

    // no snapshot ever taken
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 9, 0);
    wr_seen = 0;
    step(0, 0, 0, 0, 1);
    idle(2);
    chk("writes_no_snap", 32'(wr_seen), 32'd0);

    // snapshot and write in the same cycle
    step(0, 1, 1, 5, 0);
    wr_seen = 0;
    step(0, 0, 0, 0, 1);
    idle(3);
    chk("writes_same_cycle", 32'(wr_seen), 32'd1);

    // r0 is never tracked
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 31, 0);
    step(0, 0, 0, 0, 1);
    idle(3);

    // every register dirty, restore_req coincident with the last write
    step(0, 1, 0, 0, 0);
    for (int i = 1; i < N_REGS - 1; i++) step(0, 0, 1, i, 0);
    wr_seen = 0;
    step(0, 0, 1, N_REGS - 1, 1);
    idle(34);
    chk("writes_all", 32'(wr_seen), 32'd31);

    // reset during the second write of a four-register restore
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 2, 0);
    step(0, 0, 1, 4, 0);
    step(0, 0, 1, 6, 0);
    step(0, 0, 1, 8, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    wr_seen = 0;
    step(0, 0, 0, 0, 1);
    idle(3);
    chk("writes_after_rst", 32'(wr_seen), 32'd0);

    // randomized traffic, including inputs that must be ignored mid-restore
    for (int n = 0; n < 600; n++)
      step(($urandom % 64) == 0, ($urandom % 8) == 0, ($urandom % 2) == 0,
           int'($urandom % N_REGS), ($urandom % 12) == 0);
    idle(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
